sample_scheduler: RTL



---
 rtl/sample_sched_pkg.sv | 14 +
 rtl/sample_scheduler_sat_counter.sv | 27 ++
 rtl/sample_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sample_sched_pkg.sv
// Shared types and defaults for the sample scheduler.
package sample_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    localparam int DEF_W          = 16;
    localparam int DEF_CW         = 16;
    localparam int DEF_MAX_CYCLES = 4000;

endpackage

// File: rtl/sample_scheduler_sat_counter.sv
// Saturating up-counter; clr and inc together restart the count at 1.
module sat_counter
    import sample_sched_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    localparam logic [CW-1:0] Q_MAX = '1;
    localparam logic [CW-1:0] Q_ONE = CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? Q_ONE : '0;
        end else if (inc && (q != Q_MAX)) begin
            q <= q + Q_ONE;
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Freezes one ADC frame per strobe, runs the network handshake and latches results to the DAC.
// state     | meaning
// IDLE      | waiting for sample_strobe, frame capture on strobe
// START     | one-cycle net_start, latency counter restarts at 1
// WAIT_DONE | counting latency until net_done or MAX_CYCLES timeout
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int CW         = DEF_CW,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_strobe,
    input  logic signed [W-1:0] adc_in0,
    input  logic signed [W-1:0] adc_in1,
    input  logic signed [W-1:0] adc_in2,
    input  logic signed [W-1:0] adc_in3,
    output logic                net_start,
    output logic signed [W-1:0] net_in0,
    output logic signed [W-1:0] net_in1,
    output logic signed [W-1:0] net_in2,
    output logic signed [W-1:0] net_in3,
    input  logic                net_done,
    input  logic signed [W-1:0] net_out0,
    input  logic signed [W-1:0] net_out1,
    input  logic signed [W-1:0] net_out2,
    input  logic signed [W-1:0] net_out3,
    output logic signed [W-1:0] dac_out0,
    output logic signed [W-1:0] dac_out1,
    output logic signed [W-1:0] dac_out2,
    output logic signed [W-1:0] dac_out3,
    output logic                busy,
    output logic [CW-1:0]       last_latency,
    output logic [CW-1:0]       max_latency,
    output logic [CW-1:0]       overrun_count,
    output logic [CW-1:0]       timeout_count
);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [CW-1:0] lat_q;
    logic          at_limit;
    logic          capture;
    logic          take_done;
    logic          lat_clr;
    logic          lat_inc;
    logic          ovr_inc;
    logic          to_inc;

    // Compared at 32 bits so a MAX_CYCLES beyond the counter range never aliases.
    assign at_limit = (32'(lat_q) == 32'(MAX_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (sample_strobe) state_nxt = START;
            START:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (net_done || at_limit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        net_start = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        take_done = 1'b0;
        lat_clr   = 1'b0;
        lat_inc   = 1'b0;
        ovr_inc   = 1'b0;
        to_inc    = 1'b0;
        case (state)
            IDLE: begin
                capture = sample_strobe;
            end
            START: begin
                net_start = 1'b1;
                busy      = 1'b1;
                lat_clr   = 1'b1;
                lat_inc   = 1'b1;
                ovr_inc   = sample_strobe;
            end
            WAIT_DONE: begin
                busy      = 1'b1;
                lat_inc   = 1'b1;
                ovr_inc   = sample_strobe;
                take_done = net_done;
                to_inc    = !net_done && at_limit;
            end
            default: ;
        endcase
    end

    sat_counter #(.CW(CW)) u_lat (
        .clk (clk),
        .rst (rst),
        .clr (lat_clr),
        .inc (lat_inc),
        .q   (lat_q)
    );

    sat_counter #(.CW(CW)) u_ovr (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ovr_inc),
        .q   (overrun_count)
    );

    sat_counter #(.CW(CW)) u_to (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (to_inc),
        .q   (timeout_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            net_in0 <= '0;
            net_in1 <= '0;
            net_in2 <= '0;
            net_in3 <= '0;
        end else if (capture) begin
            net_in0 <= adc_in0;
            net_in1 <= adc_in1;
            net_in2 <= adc_in2;
            net_in3 <= adc_in3;
        end
    end

    // lat_q still holds the pre-increment count in the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_out0     <= '0;
            dac_out1     <= '0;
            dac_out2     <= '0;
            dac_out3     <= '0;
            last_latency <= '0;
            max_latency  <= '0;
        end else if (take_done) begin
            dac_out0     <= net_out0;
            dac_out1     <= net_out1;
            dac_out2     <= net_out2;
            dac_out3     <= net_out3;
            last_latency <= lat_q;
            max_latency  <= (lat_q > max_latency) ? lat_q : max_latency;
        end
    end

endmodule
